m68k_bus_arbiter: RTL and testbench
===================================

Name: m68k_bus_arbiter

Overview:
- Arbitrates the 68000 bus between the Pi-driven bus-cycle state machine and external bus masters, such as DMA cards, using the BR_n/BG_n/BGACK_n protocol.
- Gates when the Pi state machine may start a cycle. Controls tristating of AS/UDS/LDS/RW/FC and the address/data latch OEs.
- Runs in the PI_CLK (200 MHz) domain. M68K_CLK edges are detected by oversampling.

Parameters:
- SYNC_STAGES, 2, flop stages on M68K_BR_n, M68K_BGACK_n and M68K_AS_n before use.
- MIN_OWN_CYCLES, 4, M68K_CLK falling edges after regaining the bus during which BR is ignored while op_req=1 (anti-starvation).
- WDOG_CYCLES, 65535, external-tenure limit in M68K_CLK falling edges (optional feature only).

Ports:
- PI_CLK, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- M68K_CLK, input, 1, 7 MHz bus clock; sampled, never used as a clock.
- M68K_BR_n, input, 1, external bus request.
- M68K_BGACK_n, input, 1, external bus grant acknowledge.
- M68K_AS_n_in, input, 1, bus AS_n as seen on the pin (external master's strobe).
- op_req, input, 1, Pi transaction pending.
- cycle_active, input, 1, Pi state machine is in S1..S7.
- M68K_BG_n, output, 1, bus grant.
- pi_bus_avail, output, 1, Pi state machine may leave S0/Sr.
- drive_en, output, 1, Pi side drives AS/UDS/LDS/RW/FC and the latch OEs; 0 means tristate.
- ext_master, output, 1, external master owns or is being granted the bus.
- arb_state, output, 3, current state encoding for the status register.
- wdog_flag, output, 1, sticky watchdog expiry; constant 0 when the feature is compiled out.

Behaviour:
- Reset values:
  - state=OWN.
  - M68K_BG_n=1, pi_bus_avail=1, drive_en=1, ext_master=0, arb_state=0, wdog_flag=0.
  - hold-off counter=0.
- Reset mid-tenure returns to OWN immediately. The system drives M68K_RESET_n during reset, so bus contention is accepted.
- M68K_CLK edge detection:
  - 3-flop sync.
  - fall = s[2]&!s[1].
  - Every state decision below happens only on a PI_CLK cycle where fall=1.
- Synchronized inputs br=!BR_n, bgack=!BGACK_n and as=!AS_n_in are each captured in a register on fall.
- All outputs are registered and are a function of state only. Latency is 1 PI_CLK after the state register updates.
- State encoding: OWN=0, DRAIN=1, GRANT=2, EXT=3, RECLAIM=4.
- OWN:
  - Outputs: BG_n=1, avail=1, drive=1.
  - On fall with br && !bgack && (holdoff==0 || !op_req): go to DRAIN.
  - A Pi request and a BR that become visible on the same edge resolve in favour of BR. Any cycle already active completes first.
- DRAIN:
  - Outputs: BG_n=1, avail=0, drive=1.
  - On fall: if !br, go to OWN (request withdrawn); else if !cycle_active, go to GRANT.
- GRANT:
  - Outputs: BG_n=0, avail=0, drive=0, ext_master=1.
  - On fall: if bgack, go to EXT; else if !br, go to RECLAIM (BR dropped without BGACK).
- EXT:
  - Outputs: BG_n=1, drive=0, ext_master=1.
  - On fall with !bgack: if br, go to GRANT (chained master); else go to RECLAIM.
- RECLAIM:
  - Outputs: BG_n=1, drive=0, ext_master=1.
  - On fall with !as, go to OWN.
  - On entry to OWN, the hold-off counter loads MIN_OWN_CYCLES.
- Hold-off counter decrements on each fall while in OWN and saturates at 0.
- BGACK seen while in OWN or DRAIN (a master that did not request) is treated as EXT: go to EXT immediately on that fall with drive=0. This is logged as a protocol error only through arb_state.
- cycle_active rising while in DRAIN cannot happen because avail=0. If it does occur, DRAIN still waits for it to clear.

Optional Feature:
- Macro: M68K_ARB_WDOG_EN.
- With the macro defined:
  - A 16-bit counter clears on entry to GRANT and increments on each fall in GRANT/EXT.
  - At WDOG_CYCLES it saturates and sets wdog_flag.
  - wdog_flag is sticky until reset.
  - Arbitration is unaffected.
- Without the macro: no counter; wdog_flag is tied to 0.

Test Plan:
- Idle bus, BR_n low for 10 M68K_CLK periods, BGACK_n never asserted, then BR_n released → DRAIN then GRANT (BG_n=0, drive_en=0); RECLAIM on the first fall after release; OWN once AS_n_in is high.
- cycle_active=1 held for 3 M68K_CLK periods when BR_n asserts → pi_bus_avail drops on the next fall; BG_n stays 1 until the fall after cycle_active clears.
- Full handshake: BR_n low; BGACK_n low 2 periods after BG_n; BR_n high; BGACK_n high after 20 periods → BG_n returns to 1 the fall after BGACK is seen, drive_en=0 throughout, OWN within 2 falls after BGACK_n release.
- Starvation: return to OWN with op_req=1 and BR_n held low → no DRAIN for 4 falls (MIN_OWN_CYCLES=4); DRAIN on the 5th fall. Repeat with op_req=0 → DRAIN on the 1st fall.
- reset pulsed for 1 PI_CLK while in EXT → next cycle: state OWN, BG_n=1, drive_en=1, wdog_flag=0.
- With M68K_ARB_WDOG_EN and WDOG_CYCLES=8, BGACK_n held low for 12 periods → wdog_flag=1 after the 8th fall in GRANT/EXT and stays 1 after BGACK_n release; without the macro, wdog_flag stays 0.

Source files
------------

// File: rtl/m68k_bus_arbiter.sv
`timescale 1ns/1ps
// m68k_bus_arbiter: hands the 68000 bus between the Pi bus-cycle FSM and external masters (BR_n/BG_n/BGACK_n).
// Define M68K_ARB_WDOG_EN to build the external-tenure watchdog behind wdog_flag.
module m68k_bus_arbiter #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned MIN_OWN_CYCLES = 4,
  parameter int unsigned WDOG_CYCLES    = 65535
) (
  input  logic       PI_CLK,
  input  logic       reset,
  input  logic       M68K_CLK,
  input  logic       M68K_BR_n,
  input  logic       M68K_BGACK_n,
  input  logic       M68K_AS_n_in,
  input  logic       op_req,
  input  logic       cycle_active,
  output logic       M68K_BG_n,
  output logic       pi_bus_avail,
  output logic       drive_en,
  output logic       ext_master,
  output logic [2:0] arb_state,
  output logic       wdog_flag
);
  localparam int unsigned HOLD_W = (MIN_OWN_CYCLES < 1) ? 1 : $clog2(MIN_OWN_CYCLES + 1);

  typedef enum logic [2:0] {
    OWN     = 3'd0,
    DRAIN   = 3'd1,
    GRANT   = 3'd2,
    EXT     = 3'd3,
    RECLAIM = 3'd4
  } state_t;

  if (SYNC_STAGES < 1 || WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_param_check
    $error("m68k_bus_arbiter: SYNC_STAGES or WDOG_CYCLES out of range");
  end

  state_t                 state;
  logic [2:0]             clk_sync;
  logic [SYNC_STAGES-1:0] br_sync;
  logic [SYNC_STAGES-1:0] bgack_sync;
  logic [SYNC_STAGES-1:0] as_sync;
  logic [HOLD_W-1:0]      holdoff;
  logic                   fall;
  logic                   br;
  logic                   bgack;
  logic                   as_act;

  // Synchronizers; the bus-side strobes idle high.
  always_ff @(posedge PI_CLK) begin
    if (reset) begin
      clk_sync   <= '0;
      br_sync    <= '1;
      bgack_sync <= '1;
      as_sync    <= '1;
    end else begin
      clk_sync      <= {clk_sync[1:0], M68K_CLK};
      br_sync[0]    <= M68K_BR_n;
      bgack_sync[0] <= M68K_BGACK_n;
      as_sync[0]    <= M68K_AS_n_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        br_sync[i]    <= br_sync[i-1];
        bgack_sync[i] <= bgack_sync[i-1];
        as_sync[i]    <= as_sync[i-1];
      end
    end
  end

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign br     = ~br_sync[SYNC_STAGES-1];
  assign bgack  = ~bgack_sync[SYNC_STAGES-1];
  assign as_act = ~as_sync[SYNC_STAGES-1];

  // Arbitration FSM, advanced only on M68K_CLK falling edges.
  always_ff @(posedge PI_CLK) begin
    if (reset) begin
      state   <= OWN;
      holdoff <= '0;
    end else if (fall) begin
      case (state)
        OWN: begin
          if (holdoff != '0) holdoff <= holdoff - HOLD_W'(1);
          // An unrequested BGACK means someone already owns the bus.
          if (bgack) state <= EXT;
          else if (br && (holdoff == '0 || !op_req)) state <= DRAIN;
        end
        DRAIN: begin
          if (bgack) state <= EXT;
          else if (!br) state <= OWN;
          else if (!cycle_active) state <= GRANT;
        end
        GRANT: begin
          if (bgack) state <= EXT;
          else if (!br) state <= RECLAIM;
        end
        EXT: begin
          if (!bgack) state <= br ? GRANT : RECLAIM;
        end
        RECLAIM: begin
          if (!as_act) begin
            state   <= OWN;
            holdoff <= HOLD_W'(MIN_OWN_CYCLES);
          end
        end
        default: state <= OWN;
      endcase
    end
  end

  // Outputs decode the state register one PI_CLK later.
  always_ff @(posedge PI_CLK) begin
    if (reset) begin
      M68K_BG_n    <= 1'b1;
      pi_bus_avail <= 1'b1;
      drive_en     <= 1'b1;
      ext_master   <= 1'b0;
      arb_state    <= 3'd0;
    end else begin
      M68K_BG_n    <= (state != GRANT);
      pi_bus_avail <= (state == OWN);
      drive_en     <= (state == OWN) || (state == DRAIN);
      ext_master   <= (state == GRANT) || (state == EXT) || (state == RECLAIM);
      arb_state    <= 3'(state);
    end
  end

`ifdef M68K_ARB_WDOG_EN
  localparam int unsigned WDOG_W = 16;
  logic [WDOG_W-1:0] wdog_cnt;

  // Tenure counter restarts on every grant, including a chained one.
  always_ff @(posedge PI_CLK) begin
    if (reset) begin
      wdog_cnt  <= '0;
      wdog_flag <= 1'b0;
    end else if (state != GRANT && state != EXT) begin
      wdog_cnt <= '0;
    end else if (fall) begin
      if (state == EXT && !bgack && br) begin
        wdog_cnt <= '0;
      end else if (wdog_cnt != WDOG_W'(WDOG_CYCLES)) begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
        if (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) wdog_flag <= 1'b1;
      end
    end
  end
`else
  assign wdog_flag = 1'b0;
`endif

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
`timescale 1ns/1ps
// Bench for m68k_bus_arbiter: one stimulus step per M68K_CLK period, expected
// outputs queued when the step is driven and compared after the falling edge.
module tb_m68k_bus_arbiter;
  localparam int unsigned WDOG = 8;
`ifdef M68K_ARB_WDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif
  localparam logic [2:0] S_OWN = 3'd0, S_DRAIN = 3'd1, S_GRANT = 3'd2, S_EXT = 3'd3, S_RECL = 3'd4;

  logic       PI_CLK = 1'b0;
  logic       M68K_CLK = 1'b0;
  logic       reset = 1'b1;
  logic       M68K_BR_n = 1'b1;
  logic       M68K_BGACK_n = 1'b1;
  logic       M68K_AS_n_in = 1'b1;
  logic       op_req = 1'b0;
  logic       cycle_active = 1'b0;
  logic       M68K_BG_n, pi_bus_avail, drive_en, ext_master, wdog_flag;
  logic [2:0] arb_state;
  logic [7:0] obs;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [2:0]  prev_st = 3'd0;
  int unsigned wd_cnt = 0;
  logic        wd_exp = 1'b0;

  m68k_bus_arbiter #(.SYNC_STAGES(2), .MIN_OWN_CYCLES(4), .WDOG_CYCLES(WDOG)) dut (
    .PI_CLK(PI_CLK), .reset(reset), .M68K_CLK(M68K_CLK),
    .M68K_BR_n(M68K_BR_n), .M68K_BGACK_n(M68K_BGACK_n), .M68K_AS_n_in(M68K_AS_n_in),
    .op_req(op_req), .cycle_active(cycle_active),
    .M68K_BG_n(M68K_BG_n), .pi_bus_avail(pi_bus_avail), .drive_en(drive_en),
    .ext_master(ext_master), .arb_state(arb_state), .wdog_flag(wdog_flag)
  );

  assign obs = {arb_state, M68K_BG_n, pi_bus_avail, drive_en, ext_master, wdog_flag};

  always #2.5 PI_CLK = ~PI_CLK;
  initial begin
    #1.3;
    forever #70 M68K_CLK = ~M68K_CLK;
  end

  initial begin
    #100_000;
    $display("FAIL timeout: bench did not complete (CHECKS %0d ERRORS %0d)", checks, errors);
    $fatal(1);
  end

  // Outputs per state: {state, BG_n, avail, drive, ext_master, wdog}.
  function automatic logic [7:0] ex(input logic [2:0] st, input logic wd);
    case (st)
      S_OWN:   return {st, 4'b1110, wd};
      S_DRAIN: return {st, 4'b1010, wd};
      S_GRANT: return {st, 4'b0001, wd};
      default: return {st, 4'b1001, wd};
    endcase
  endfunction

  // Step entry: {BR_n, BGACK_n, AS_n, op_req, cycle_active, state after the fall}.
  function automatic logic [7:0] mk(input logic br_n, input logic bgack_n, input logic as_n,
                                    input logic op, input logic ca, input logic [2:0] st);
    return {br_n, bgack_n, as_n, op, ca, st};
  endfunction

  // Expected outputs for the next state, with the watchdog tracked from the state sequence.
  task automatic push_exp(input logic [2:0] nst);
    if (WD_ON) begin
      if (prev_st == S_EXT && nst == S_GRANT) wd_cnt = 0;
      else if (prev_st == S_GRANT || prev_st == S_EXT) begin
        if (wd_cnt < WDOG) wd_cnt++;
        if (wd_cnt == WDOG) wd_exp = 1'b1;
      end else wd_cnt = 0;
    end
    exp_q.push_back(ex(nst, wd_exp));
    prev_st = nst;
  endtask

  task automatic do_reset();
    @(negedge PI_CLK);
    reset = 1'b1;
    M68K_BR_n = 1'b1; M68K_BGACK_n = 1'b1; M68K_AS_n_in = 1'b1; op_req = 1'b0; cycle_active = 1'b0;
    repeat (3) @(negedge PI_CLK);
    reset = 1'b0;
    prev_st = S_OWN; wd_cnt = 0; wd_exp = 1'b0;
    exp_q.delete();
  endtask

  // Drive one M68K_CLK period and wait until that period's fall has reached the outputs.
  task automatic apply(input logic [7:0] e);
    @(posedge M68K_CLK);
    #1;
    {M68K_BR_n, M68K_BGACK_n, M68K_AS_n_in, op_req, cycle_active} = e[7:3];
    push_exp(e[2:0]);
    @(negedge M68K_CLK);
    repeat (8) @(negedge PI_CLK);
  endtask

  task automatic test_reset();
    logic [7:0] want;
    do_reset();
    push_exp(S_OWN);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_state: got %b want %b", obs, want); end
    for (int i = 0; i < 2; i++) begin
      apply(mk(1, 1, 1, 1, 0, S_OWN));
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL reset_idle step %0d: got %b want %b", i, obs, want); end
    end
  endtask

  task automatic test_br_no_bgack();
    logic [7:0] t[$];
    logic [7:0] want;
    do_reset();
    t.push_back(mk(0, 1, 1, 0, 0, S_DRAIN));
    for (int i = 0; i < 9; i++) t.push_back(mk(0, 1, 1, 0, 0, S_GRANT));
    t.push_back(mk(1, 1, 0, 0, 0, S_RECL));
    t.push_back(mk(1, 1, 0, 0, 0, S_RECL));
    t.push_back(mk(1, 1, 1, 0, 0, S_OWN));
    foreach (t[i]) begin
      apply(t[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL br_no_bgack step %0d: got %b want %b", i, obs, want); end
    end
  endtask

  task automatic test_cycle_active();
    logic [7:0] t[$];
    logic [7:0] want;
    do_reset();
    for (int i = 0; i < 3; i++) t.push_back(mk(0, 1, 1, 1, 1, S_DRAIN));
    t.push_back(mk(0, 1, 1, 1, 0, S_GRANT));
    t.push_back(mk(1, 1, 1, 0, 0, S_RECL));
    t.push_back(mk(1, 1, 1, 0, 0, S_OWN));
    t.push_back(mk(0, 1, 1, 0, 1, S_DRAIN));
    t.push_back(mk(1, 1, 1, 0, 1, S_OWN));
    t.push_back(mk(1, 1, 1, 0, 0, S_OWN));
    foreach (t[i]) begin
      apply(t[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL cycle_active step %0d: got %b want %b", i, obs, want); end
    end
  endtask

  task automatic test_handshake();
    logic [7:0] t[$];
    logic [7:0] want;
    do_reset();
    t.push_back(mk(0, 1, 1, 0, 0, S_DRAIN));
    t.push_back(mk(0, 1, 1, 0, 0, S_GRANT));
    t.push_back(mk(0, 1, 1, 0, 0, S_GRANT));
    t.push_back(mk(0, 0, 0, 0, 0, S_EXT));
    for (int i = 0; i < 20; i++) t.push_back(mk(1, 0, 0, 0, 0, S_EXT));
    t.push_back(mk(1, 1, 0, 0, 0, S_RECL));
    t.push_back(mk(1, 1, 1, 0, 0, S_OWN));
    foreach (t[i]) begin
      apply(t[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL handshake step %0d: got %b want %b", i, obs, want); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] t[$];
    logic [7:0] want;
    do_reset();
    t.push_back(mk(0, 1, 1, 0, 0, S_DRAIN));
    t.push_back(mk(0, 1, 1, 0, 0, S_GRANT));
    t.push_back(mk(0, 0, 1, 0, 0, S_EXT));
    t.push_back(mk(0, 1, 1, 0, 0, S_GRANT));
    t.push_back(mk(0, 0, 1, 0, 0, S_EXT));
    t.push_back(mk(1, 1, 1, 0, 0, S_RECL));
    t.push_back(mk(1, 1, 1, 0, 0, S_OWN));
    t.push_back(mk(1, 0, 1, 0, 0, S_EXT));
    t.push_back(mk(1, 1, 1, 0, 0, S_RECL));
    t.push_back(mk(1, 1, 1, 0, 0, S_OWN));
    t.push_back(mk(0, 1, 1, 0, 0, S_DRAIN));
    t.push_back(mk(0, 0, 1, 0, 0, S_EXT));
    t.push_back(mk(1, 1, 1, 0, 0, S_RECL));
    t.push_back(mk(1, 1, 1, 0, 0, S_OWN));
    foreach (t[i]) begin
      apply(t[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL back_to_back step %0d: got %b want %b", i, obs, want); end
    end
  endtask

  task automatic test_starvation();
    logic [7:0] t[$];
    logic [7:0] want;
    do_reset();
    t.push_back(mk(0, 1, 1, 0, 0, S_DRAIN));
    t.push_back(mk(0, 1, 1, 0, 0, S_GRANT));
    t.push_back(mk(1, 1, 1, 1, 0, S_RECL));
    t.push_back(mk(0, 1, 1, 1, 0, S_OWN));
    for (int i = 0; i < 4; i++) t.push_back(mk(0, 1, 1, 1, 0, S_OWN));
    t.push_back(mk(0, 1, 1, 1, 0, S_DRAIN));
    t.push_back(mk(0, 1, 1, 1, 0, S_GRANT));
    t.push_back(mk(1, 1, 1, 1, 0, S_RECL));
    t.push_back(mk(0, 1, 1, 0, 0, S_OWN));
    t.push_back(mk(0, 1, 1, 0, 0, S_DRAIN));
    t.push_back(mk(1, 1, 1, 0, 0, S_OWN));
    foreach (t[i]) begin
      apply(t[i]);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin errors++; $display("FAIL starvation step %0d: got %b want %b", i, obs, want); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] want;
    do_reset();
    apply(mk(1, 0, 0, 0, 0, S_EXT));
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_mid_enter: got %b want %b", obs, want); end
    reset = 1'b1;
    @(negedge PI_CLK);
    reset = 1'b0;
    prev_st = S_OWN; wd_cnt = 0; wd_exp = 1'b0;
    push_exp(S_OWN);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_mid_own: got %b want %b", obs, want); end
    M68K_BGACK_n = 1'b1; M68K_AS_n_in = 1'b1;
    apply(mk(1, 1, 1, 0, 0, S_OWN));
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin errors++; $display("FAIL reset_mid_after: got %b want %b", obs, want); end
  endtask

  task automatic test_wdog();
    logic [7:0] t[$];
    logic [7:0] want;
    logic       flag_want;
    do_reset();
    t.push_back(mk(0, 1, 1, 0, 0, S_DRAIN));
    t.push_back(mk(0, 1, 1, 0, 0, S_GRANT));
    for (int i = 0; i < 12; i++) t.push_back(mk(1, 0, 0, 0, 0, S_EXT));
    t.push_back(mk(1, 1, 0, 0, 0, S_RECL));
    t.push_back(mk(1, 1, 1, 0, 0, S_OWN));
    t.push_back(mk(1, 1, 1, 0, 0, S_OWN));
    t.push_back(mk(1, 1, 1, 0, 0, S_OWN));
    foreach (t[i]) begin
      apply(t[i]);
      want = exp_q.pop_front();
      flag_want = WD_ON && (i >= 9);
      checks++;
      if (obs !== want) begin errors++; $display("FAIL wdog step %0d: got %b want %b", i, obs, want); end
      checks++;
      if (wdog_flag !== flag_want) begin
        errors++; $display("FAIL wdog_flag step %0d: got %b want %b", i, wdog_flag, flag_want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_br_no_bgack();
    test_cycle_active();
    test_handshake();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    test_wdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
